// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// address type and the zeroing-sweep state encoding.
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_REG_W    = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_REG_W-1:0] reg_addr_t;

   typedef enum logic {IDLE, SWEEP} rf_init_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for the hazard unit: flush beats issue, issue beats
// writeback clear. Busy lookups are registered state only, never bypassed.
module rf_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    issue_en,
   input  logic [REG_W-1:0]        issue_addr,
   input  logic [NUM_WR-1:0]       wr_commit,
   input  logic [NUM_WR*REG_W-1:0] wr_addr,
   input  logic [NUM_RD*REG_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]       rd_busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Later assignments override earlier ones, which encodes the priority order.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (wr_commit[w]) busy_d[wr_addr[w*REG_W +: REG_W]] = 1'b0;
      end
      if (issue_en && issue_addr != '0) busy_d[issue_addr] = 1'b1;
      if (flush) busy_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = (rd_addr[i*REG_W +: REG_W] != '0) && busy_q[rd_addr[i*REG_W +: REG_W]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, busy
// scoreboard and a sequenced zeroing sweep for soft re-initialisation.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int   DATA_W   = DEF_DATA_W,
   parameter int   NUM_REGS = DEF_NUM_REGS,
   parameter int   NUM_RD   = 2,
   parameter int   NUM_WR   = 2,
   localparam int  REG_W    = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*REG_W-1:0]  rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*REG_W-1:0]  wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     issue_en,
   input  logic [REG_W-1:0]         issue_addr,
   input  logic                     flush,
   input  logic                     init_req,
   output logic                     init_busy
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   rf_init_state_t    state_q, state_d;
   logic [REG_W-1:0]  cnt_q, cnt_d;
   logic              sweeping;
   logic [NUM_WR-1:0] wr_commit;

   assign sweeping  = (state_q == SWEEP);
   assign init_busy = sweeping;

   always_comb begin
      wr_commit = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wr_commit[w] = !sweeping && wr_en[w] && (wr_addr[w*REG_W +: REG_W] != '0);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (init_req) begin
               state_d = SWEEP;
               cnt_d   = REG_W'(1);
            end
         end
         SWEEP: begin
            if (cnt_q == REG_W'(NUM_REGS - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + REG_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the array is reset on purpose; a cleared file is architecturally
   // visible after reset, so this cannot map onto reset-less RAM macros.
   // Ascending port order lets the highest-index port win a same-address conflict.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      end else if (sweeping) begin
         mem[cnt_q] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_commit[w]) mem[wr_addr[w*REG_W +: REG_W]] <= wr_data[w*DATA_W +: DATA_W];
         end
      end
   end

   // Bypass is suppressed during the sweep because write ports are ignored there.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_addr[i*REG_W +: REG_W] != '0) begin
            rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*REG_W +: REG_W]];
            for (int w = 0; w < NUM_WR; w++) begin
               if (!sweeping && wr_en[w] && wr_addr[w*REG_W +: REG_W] == rd_addr[i*REG_W +: REG_W])
                  rd_data[i*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
            end
         end
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .flush      (!sweeping && (flush || init_req)),
      .issue_en   (!sweeping && issue_en),
      .issue_addr (issue_addr),
      .wr_commit  (wr_commit),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .rd_busy    (rd_busy)
   );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the pipeline's single-write / two-read register file.
- Adds:
  - N read ports and M write ports.
  - Same-cycle write-to-read bypass. Writes move to the posedge; the negedge-write trick is retired.
  - Per-register busy scoreboard for the hazard unit.
  - Sequenced zeroing sweep (INIT) for soft re-initialisation without reset.
- Sits between decode (read/issue) and writeback (ALU port 0, load port 1).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, >=4).
- REG_W, $clog2(NUM_REGS), address width (derived, not overridden).
- NUM_RD, 2, read ports (1..4).
- NUM_WR, 2, write ports (1..3).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*REG_W  packed read addresses; port i at [i*REG_W +: REG_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  busy bit of the register addressed by each read port.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR*REG_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- issue_en  in  1  mark issue_addr busy (new in-flight producer).
- issue_addr  in  REG_W  destination register being issued.
- flush  in  1  clear all busy bits.
- init_req  in  1  start zeroing sweep.
- init_busy  out  1  high while the sweep runs.

Behaviour:
- Reset (reset low, async):
  - All registers = 0.
  - All busy bits = 0.
  - FSM = IDLE, sweep counter = 0, init_busy = 0.
  - rd_data/rd_busy then follow combinationally from the cleared state, so all read 0.
- Register 0:
  - Reads always return 0 and rd_busy = 0.
  - Writes and issues to address 0 are dropped.
- Writes:
  - Committed at posedge for each port with wr_en=1 and wr_addr!=0.
  - Two ports writing the same address in one cycle: the highest-index port wins.
- Reads are combinational with bypass:
  - If any enabled write port targets rd_addr (nonzero) this cycle, rd_data returns that port's wr_data, using the same highest-index priority.
  - Otherwise rd_data returns stored contents.
  - Read latency is 0 cycles; written value is visible in the same cycle via bypass.
- Scoreboard, updated at posedge. Priority per register, highest first:
  1. flush clears all bits.
  2. issue_en sets busy[issue_addr].
  3. Any committed write to r clears busy[r].
- Scoreboard edge cases:
  - issue and write to the same register in one cycle leave it busy (new producer).
  - flush together with issue leaves everything clear.
- rd_busy is not bypassed; it reflects registered busy state only.
- FSM states IDLE, SWEEP:
  - IDLE -> SWEEP when init_req=1.
    - On entry: counter = 1, all busy bits cleared.
  - In SWEEP, each cycle:
    - Write 0 to register[counter], then counter++.
    - After writing NUM_REGS-1, return to IDLE.
    - Duration is exactly NUM_REGS-1 cycles.
  - init_busy = 1 exactly while in SWEEP.
  - Ignored in SWEEP: wr_en, issue_en, flush, init_req.
  - Reads in SWEEP return stored contents with bypass disabled.
- Reset asserted mid-sweep: immediate return to IDLE, all registers zeroed.

Decomposition:
- Shared package regfile_pkg:
  - Default DATA_W/NUM_REGS constants.
  - reg_addr_t typedef.
  - typedef enum logic {IDLE, SWEEP} rf_init_state_t.
- One natural sub-module: rf_scoreboard (busy vector, issue/flush/clear priority, per-port rd_busy lookup).
- Storage, bypass muxing and the sweep FSM stay in regfile_mp.

Test Plan:
- Basic write/read: after reset, write 0xDEADBEEF to r5 on port 0, read r5 next cycle on port 1 -> 0xDEADBEEF; read r7 -> 0.
- Same-cycle bypass and x0:
  - Write r9=0x1234 while reading r9 in the same cycle -> rd_data=0x1234 before the edge.
  - Write r0=0xFFFF -> r0 reads 0.
- Write-port conflict: port0 r3=0xAAAA and port1 r3=0x5555 in one cycle -> bypass and next-cycle read both 0x5555.
- Scoreboard:
  - issue r4 -> rd_busy=1 next cycle.
  - Writeback to r4 -> 0.
  - Simultaneous issue r6 + write r6 -> stays 1.
  - flush + issue r8 -> all busy 0.
- Sweep:
  - Preload r1..r31 with nonzero values, pulse init_req -> init_busy high exactly 31 cycles; all registers read 0 afterwards.
  - wr_en during the sweep has no effect.
- Async reset mid-sweep: assert reset at sweep cycle 10 -> init_busy 0 immediately; all reads 0; post-reset write/read of r2 works.
